fifo_stream_reader: RTL and testbench

//  Consumer end of sync_fifo. Pops words from the FIFO read port, which has a
//  1-cycle read latency, and re-times them onto a valid/ready output stream.
//  A BUF_DEPTH-entry output buffer absorbs read latency and downstream stalls.

---
 rtl/fifo_stream_reader.sv | 108 ++++++++++
 tb/tb_fifo_stream_reader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Consumer end of a sync_fifo: pops words (1-clk read latency) into a small buffer
// and presents them on a valid/ready stream with m_last every BURST_LEN words.
// Optional FIFO_RD_STATS_EN adds a 32-bit rd_count of words delivered on m_*.
module fifo_stream_reader #(
    parameter int DW        = 16,
    parameter int BUF_DEPTH = 3,
    parameter int BURST_LEN = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic          fifo_empty,
    output logic          fifo_rd_en,
    input  logic [DW-1:0] fifo_dout,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic          busy,
    output logic [1:0]    state_dbg
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [31:0]   rd_count
`endif
);

    localparam int OW = $clog2(BUF_DEPTH + 2);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [OW-1:0] occ, occ_next, pending;
    logic          inflight;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [DW-1:0] buf_mem [BUF_DEPTH];
    logic [CW-1:0] burst_cnt;
    logic          pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit covers buffered plus in-flight words, so a read is only issued when a
    // slot is guaranteed; rstn gating keeps the FIFO untouched while in reset.
    assign pending    = occ + OW'(inflight);
    assign fifo_rd_en = rstn & en & ~fifo_empty & (pending < OW'(BUF_DEPTH));

    // Stream handshake: a word transfers on a rising edge where m_valid & m_ready;
    // once m_valid rises, m_data/m_last hold until that transfer happens.
    assign m_valid   = (occ != '0);
    assign m_data    = buf_mem[rd_ptr];
    assign m_last    = m_valid & (burst_cnt == CW'(BURST_LEN - 1));
    assign pop       = m_valid & m_ready;
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;
    assign occ_next  = occ + OW'(inflight) - OW'(pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            occ       <= '0;
            inflight  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            burst_cnt <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= '0;
        end else begin
            state    <= state_next;
            occ      <= occ_next;
            inflight <= fifo_rd_en;
            if (inflight) begin
                buf_mem[wr_ptr] <= fifo_dout;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr    <= ptr_inc(rd_ptr);
                burst_cnt <= (burst_cnt == CW'(BURST_LEN - 1)) ? '0 : burst_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (en) state_next = S_ACTIVE;
            S_ACTIVE: if (!en) state_next = (pending != '0) ? S_DRAIN : S_IDLE;
            S_DRAIN: begin
                if (en)                   state_next = S_ACTIVE;
                else if (pending == '0)   state_next = S_IDLE;
            end
            default:  state_next = S_IDLE;
        endcase
    end

`ifdef FIFO_RD_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                         rd_count <= '0;
        else if (pop && state != S_IDLE)   rd_count <= rd_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed + randomized bench for fifo_stream_reader with a queue-based FIFO model
// and a scoreboard of words pushed but not yet delivered.
module tb_fifo_stream_reader;

    localparam int DW        = 16;
    localparam int BUF_DEPTH = 3;
    localparam int BURST_LEN = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          en;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_dout;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic [1:0]    state_dbg;
`ifdef FIFO_RD_STATS_EN
    logic [31:0]   rd_count;
`endif

    always #5 clk = ~clk;

    fifo_stream_reader #(.DW(DW), .BUF_DEPTH(BUF_DEPTH), .BURST_LEN(BURST_LEN)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .state_dbg  (state_dbg)
`ifdef FIFO_RD_STATS_EN
        ,
        .rd_count   (rd_count)
`endif
    );

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int            deliv;
    logic [31:0]   count_model;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    int            rd_pulses;
    int            pushed;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        fifo_empty <= 1'b0;
    endtask

    // Reset drops buffered/in-flight words: what is still in the FIFO is what comes next.
    task automatic model_reset();
        exp_q       = fifo_q;
        deliv       = 0;
        count_model = 0;
        prev_stall  = 0;
    endtask

    task automatic monitor();
        logic [DW-1:0] exp_w;
        if (rstn !== 1'b1) begin
            prev_stall = 0;
            return;
        end
        if (fifo_empty === 1'b1) check("rd_en_while_empty", fifo_rd_en, 0);
        if (prev_stall) begin
            check("stall_valid", m_valid, 1);
            check("stall_data", m_data, prev_data);
            check("stall_last", m_last, prev_last);
        end
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            check("word_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                exp_w = exp_q.pop_front();
                check("stream_data", m_data, exp_w);
                check("stream_last", m_last, ((deliv % BURST_LEN) == BURST_LEN - 1));
            end
            deliv++;
            count_model++;
        end
        prev_stall = (m_valid === 1'b1) && (m_ready !== 1'b1);
        prev_data  = m_data;
        prev_last  = m_last;
    endtask

    // One clock: sample mid-low-phase, then model the FIFO's registered read.
    task automatic tick();
        bit rd_now;
        #3;
        monitor();
        rd_now = (fifo_rd_en === 1'b1);
        if (rd_now) rd_pulses++;
        @(posedge clk);
        if (rd_now && fifo_q.size() != 0) fifo_dout <= fifo_q.pop_front();
        fifo_empty <= (fifo_q.size() == 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; en = 1'b0; m_ready = 1'b0;
        fifo_empty <= 1'b1;
        fifo_dout  <= '0;
        rd_pulses = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset_m_valid", m_valid, 0);
        check("reset_m_last", m_last, 0);
        check("reset_m_data", m_data, 0);
        check("reset_busy", busy, 0);
        check("reset_rd_en", fifo_rd_en, 0);
        check("reset_state", state_dbg, 0);
`ifdef FIFO_RD_STATS_EN
        check("reset_rd_count", rd_count, 0);
`endif
        rstn = 1'b1;
        @(negedge clk);

        // 1: 16 preloaded words, full rate
        for (int i = 1; i <= 16; i++) push_word(16'(i));
        en = 1'b1; m_ready = 1'b1;
        #1;
        check("t1_rd_en_first", fifo_rd_en, 1);
        check("t1_valid_c0", m_valid, 0);
        tick(); #1;
        check("t1_valid_c1", m_valid, 0);
        tick(); #1;
        check("t1_valid_c2", m_valid, 1);
        check("t1_first_data", m_data, 16'h0001);
        check("t1_busy", busy, 1);
        repeat (16) tick();
        #1;
        check("t1_all_delivered", exp_q.size(), 0);
        check("t1_valid_after", m_valid, 0);

        // 2: downstream stalled, buffer fills to BUF_DEPTH
        for (int i = 0; i < 5; i++) push_word(16'h0A00 + 16'(i));
        m_ready = 1'b0;
        rd_pulses = 0;
        repeat (8) tick();
        #1;
        check("t2_rd_pulses", rd_pulses, BUF_DEPTH);
        check("t2_valid_held", m_valid, 1);
        check("t2_head_held", m_data, 16'h0A00);
        m_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        check("t2_drained", exp_q.size(), 0);

        // 3: en drops with a read in flight
        for (int i = 0; i < 10; i++) push_word(16'h0B00 + 16'(i));
        tick();
        en = 1'b0;
        #1;
        check("t3_rd_en_off", fifo_rd_en, 0);
        tick(); #1;
        check("t3_state_drain", state_dbg, 2);
        check("t3_busy_drain", busy, 1);
        for (int k = 0; k < 12 && busy === 1'b1; k++) begin
            tick(); #1;
            check("t3_no_rd_in_drain", fifo_rd_en, 0);
        end
        check("t3_idle", busy, 0);
        check("t3_fifo_left", fifo_q.size(), 9);
        check("t3_no_loss", exp_q.size(), fifo_q.size());

        // 4: random traffic, random backpressure, occasional en drops
        pushed = 0;
        for (int cyc = 0; cyc < 5000 && !(pushed == 200 && exp_q.size() == 0); cyc++) begin
            if (pushed < 200 && $urandom_range(0, 2) != 0) begin
                push_word(16'($urandom));
                pushed++;
            end
            m_ready = 1'($urandom_range(0, 1));
            en = (pushed == 200) ? 1'b1 : ($urandom_range(0, 9) != 0);
            tick();
        end
        check("t4_all_delivered", exp_q.size(), 0);
        check("t4_fifo_empty", fifo_q.size(), 0);

        // 5: reset with two words buffered
        m_ready = 1'b0; en = 1'b1;
        push_word(16'h0C01);
        push_word(16'h0C02);
        repeat (5) tick();
        #1;
        check("t5_valid_before", m_valid, 1);
        check("t5_head_before", m_data, 16'h0C01);
        en = 1'b0;
        repeat (2) tick();
        for (int i = 3; i <= 5; i++) push_word(16'h0C00 + 16'(i));
        #1;
        check("t5_no_rd_drain", fifo_rd_en, 0);
        rstn = 1'b0;
        model_reset();
        #1;
        check("t5_rst_valid", m_valid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_rd_en", fifo_rd_en, 0);
        check("t5_rst_last", m_last, 0);
`ifdef FIFO_RD_STATS_EN
        check("t5_rst_rd_count", rd_count, 0);
`endif
        repeat (2) tick();
        rstn = 1'b1; en = 1'b1; m_ready = 1'b0;
        for (int k = 0; k < 10 && m_valid !== 1'b1; k++) tick();
        check("t5_head_after", m_data, 16'h0C03);
        m_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        check("t5_drained", exp_q.size(), 0);

        // 6: 20 words delivered since the last reset, then count survives idle
        for (int i = 0; i < 17; i++) push_word(16'h0D00 + 16'(i));
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) tick();
        en = 1'b0;
        repeat (4) tick();
        #1;
        check("t6_delivered", deliv, 20);
        check("t6_idle", busy, 0);
`ifdef FIFO_RD_STATS_EN
        check("t6_rd_count", rd_count, count_model);
        check("t6_rd_count_20", rd_count, 32'd20);
        rstn = 1'b0;
        model_reset();
        #1;
        check("t6_rd_count_rst", rd_count, 0);
        rstn = 1'b1;
`endif
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
